// File: rtl/rotate_pkg.sv
// Shared types and constants for the multi-step rotate sequencer.
package rotate_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } rot_state_t;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/rotateN.sv
// Combinational single-bit rotator: DIR_RIGHT moves bit 0 to the MSB, DIR_LEFT moves the MSB to bit 0.
module rotateN
    import rotate_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    input  logic         dir,
    output logic [N-1:0] dout
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            dout = {din[0], din[N-1:1]};
        end else begin
            dout = {din[N-2:0], din[N-1]};
        end
    end

endmodule

// File: rtl/rotate_seq.sv
// Sequencer that applies one single-bit rotation per clock until the requested amount is reached,
// then holds the result until ACK; ABORT cancels from ROT or HOLD.
//   state | meaning
//   IDLE  | waiting for START, register and STEPS retained
//   ROT   | one rotation per edge until STEPS == captured amount
//   HOLD  | result stable, DONE high until ACK or ABORT
module rotate_seq
    import rotate_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          START,
    input  logic [N-1:0]  DIN,
    input  logic          DIR,
    input  logic [CW-1:0] AMT,
    input  logic          ABORT,
    input  logic          ACK,
    output logic          BUSY,
    output logic          DONE,
    output logic [N-1:0]  DOUT,
    output logic [CW-1:0] STEPS
);

    localparam logic [CW-1:0] AMT_MAX = CW'(N - 1);

    rot_state_t    state_q, state_d;
    logic [N-1:0]  work_q;
    logic          dir_q;
    logic [CW-1:0] amt_q;
    logic [CW-1:0] steps_q;
    logic [N-1:0]  rot_next;
    logic [CW-1:0] amt_clamped;
    logic          load_en;
    logic          step_en;

    rotateN #(.N(N)) u_rotate (
        .din  (work_q),
        .dir  (dir_q),
        .dout (rot_next)
    );

    // Only reachable when N is not a power of two.
    assign amt_clamped = (AMT > AMT_MAX) ? AMT_MAX : AMT;

    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        step_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = ROT;
                    load_en = 1'b1;
                end
            end
            ROT: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (steps_q == amt_q) begin
                    state_d = HOLD;
                end else begin
                    step_en = 1'b1;
                end
            end
            HOLD: begin
                if (ABORT || ACK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            work_q  <= '0;
            dir_q   <= DIR_LEFT;
            amt_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                work_q  <= DIN;
                dir_q   <= DIR;
                amt_q   <= amt_clamped;
                steps_q <= '0;
            end else if (step_en) begin
                work_q  <= rot_next;
                steps_q <= steps_q + CW'(1);
            end
        end
    end

    assign BUSY  = (state_q != IDLE);
    assign DONE  = (state_q == HOLD);
    assign DOUT  = work_q;
    assign STEPS = steps_q;

endmodule

// File: tb/tb_rotate_seq.sv
// Randomized and directed bench for rotate_seq against a closed-form rotation model.
module tb_rotate_seq;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          START = 1'b0;
    logic [N-1:0]  DIN = '0;
    logic          DIR = 1'b0;
    logic [CW-1:0] AMT = '0;
    logic          ABORT = 1'b0;
    logic          ACK = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic [N-1:0]  DOUT;
    logic [CW-1:0] STEPS;

    int n_checks = 0;
    int n_errors = 0;

    // model: time since capture, with outputs derived from min(t, amt)
    bit         m_active;
    bit         m_done;
    int         m_t;
    int         m_amt;
    bit         m_dir;
    logic [N-1:0] m_din;
    logic [N-1:0] m_dout;
    int         m_steps;

    rotate_seq #(.N(N), .CW(CW)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .START (START),
        .DIN   (DIN),
        .DIR   (DIR),
        .AMT   (AMT),
        .ABORT (ABORT),
        .ACK   (ACK),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DOUT  (DOUT),
        .STEPS (STEPS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rot_by(input logic [N-1:0] d, input bit right, input int k);
        if (k == 0) return d;
        if (right) return (d >> k) | (d << (N - k));
        return (d << k) | (d >> (N - k));
    endfunction

    function automatic void model_reset();
        m_active = 0; m_done = 0; m_t = 0; m_amt = 0; m_dir = 0;
        m_din = '0; m_dout = '0; m_steps = 0;
    endfunction

    function automatic void model_edge();
        if (!m_active) begin
            if (START) begin
                m_active = 1; m_done = 0; m_t = 0;
                m_din = DIN; m_dir = DIR; m_amt = int'(AMT);
                m_dout = DIN; m_steps = 0;
            end
        end else if (ABORT) begin
            m_active = 0; m_done = 0;
        end else if (m_done) begin
            if (ACK) begin
                m_active = 0; m_done = 0;
            end
        end else begin
            m_t++;
            m_steps = (m_t < m_amt) ? m_t : m_amt;
            m_dout  = rot_by(m_din, m_dir, m_steps);
            m_done  = (m_t > m_amt);
        end
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ".busy"}, 32'(BUSY), 32'(m_active));
        chk({tag, ".done"}, 32'(DONE), 32'(m_done));
        chk({tag, ".dout"}, 32'(DOUT), 32'(m_dout));
        chk({tag, ".steps"}, 32'(STEPS), 32'(m_steps));
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic launch(input logic [N-1:0] d, input logic dr, input logic [CW-1:0] a);
        START = 1'b1; DIN = d; DIR = dr; AMT = a;
        step("cap");
        START = 1'b0; DIN = $urandom; DIR = $urandom; AMT = $urandom;
    endtask

    initial begin
        model_reset();
        #12;
        compare_all("reset");
        nRST = 1'b1;
        step("idle");

        // rotate right by 3
        launch(8'b10101100, 1'b1, 3'd3);
        repeat (3) step("rr");
        chk("rr_notdone", 32'(DONE), 32'd0);
        step("rr");
        chk("rr_final", 32'(DOUT), 32'h95);
        chk("rr_done", 32'(DONE), 32'd1);
        repeat (2) step("rr_hold");
        ACK = 1'b1; step("rr_ack"); ACK = 1'b0;

        // rotate left by 2
        launch(8'b10101100, 1'b0, 3'd2);
        repeat (3) step("rl");
        chk("rl_final", 32'(DOUT), 32'hB2);
        ACK = 1'b1; step("rl_ack"); ACK = 1'b0;
        chk("rl_idle_busy", 32'(BUSY), 32'd0);
        chk("rl_retained", 32'(DOUT), 32'hB2);

        // zero amount
        launch(8'hA5, 1'b1, 3'd0);
        step("z");
        chk("z_done", 32'(DONE), 32'd1);
        chk("z_dout", 32'(DOUT), 32'hA5);
        ACK = 1'b1; step("z_ack"); ACK = 1'b0;

        // abort after two rotations, with an ignored START mid-ROT
        launch(8'b10101100, 1'b1, 3'd5);
        START = 1'b1; DIN = 8'hFF; step("ab"); START = 1'b0;
        step("ab");
        ABORT = 1'b1; step("ab_abort"); ABORT = 1'b0;
        chk("ab_dout", 32'(DOUT), 32'h2B);
        chk("ab_done", 32'(DONE), 32'd0);
        step("ab_idle");

        // ABORT and ACK together in HOLD
        launch(8'h3C, 1'b0, 3'd1);
        repeat (2) step("aa");
        ABORT = 1'b1; ACK = 1'b1; step("aa_both"); ABORT = 1'b0; ACK = 1'b0;
        chk("aa_dout", 32'(DOUT), 32'h78);

        // back-to-back: START with ACK not accepted
        launch(8'h81, 1'b1, 3'd1);
        repeat (2) step("bb");
        ACK = 1'b1; START = 1'b1; DIN = 8'h0F; step("bb_ack");
        ACK = 1'b0;
        chk("bb_not_busy", 32'(BUSY), 32'd0);
        step("bb_cap"); START = 1'b0;
        chk("bb_busy", 32'(BUSY), 32'd1);
        step("bb");

        // async reset mid-ROT
        launch(8'hC3, 1'b0, 3'd6);
        repeat (2) step("ar");
        #3 nRST = 1'b0;
        #1;
        model_reset();
        compare_all("ar_async");
        #2 nRST = 1'b1;
        launch(8'h12, 1'b1, 3'd4);
        repeat (6) step("ar_after");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            START = ($urandom_range(0, 3) == 0);
            DIN   = $urandom;
            DIR   = $urandom;
            AMT   = $urandom;
            ABORT = ($urandom_range(0, 15) == 0);
            ACK   = ($urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
